// File: rtl/uart_rx_if.sv
// Signal bundle for uart_rx: serial line and enable in, received byte and status strobes out.
// master = receiver side, slave = the block that feeds the line and consumes the byte.
interface uart_rx_if;
    logic       i_run;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_parity_err;
    logic       o_busy;

    modport master (
        input  i_run, i_rx,
        output o_data, o_valid, o_frame_err, o_parity_err, o_busy
    );

    modport slave (
        output i_run, i_rx,
        input  o_data, o_valid, o_frame_err, o_parity_err, o_busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver for 8N1 frames (LSB first) with mid-bit sampling and frame-error detection.
// Optional feature macro UART_RX_PARITY_EN adds one even-parity bit between data and stop.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115_200
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       data, data_n;
    logic             valid, valid_n;
    logic             frame_err, frame_err_n;
    logic             busy, busy_n;
    logic             rx_meta, rx_s;
`ifdef UART_RX_PARITY_EN
    logic             par_bad, par_bad_n;
    logic             parity_err, parity_err_n;
`endif

    // Next-state and strobe logic; every sample point sits at a counter terminal value.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        data_n      = data;
        valid_n     = 1'b0;
        frame_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n    = par_bad;
        parity_err_n = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (bus.i_run && !rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    par_bad_n = rx_s ^ (^shift);
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_n = par_bad;
`endif
                        state_n = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Disable wins over everything: abort the frame silently, keep the last byte.
        if (!bus.i_run) begin
            state_n     = IDLE;
            cnt_n       = '0;
            data_n      = data;
            valid_n     = 1'b0;
            frame_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_n = 1'b0;
`endif
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_meta   <= bus.i_rx;
            rx_s      <= rx_meta;
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
            busy      <= busy_n;
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_n;
            parity_err <= parity_err_n;
`endif
        end
    end

    assign bus.o_data      = data;
    assign bus.o_valid     = valid;
    assign bus.o_frame_err = frame_err;
    assign bus.o_busy      = busy;
`ifdef UART_RX_PARITY_EN
    assign bus.o_parity_err = parity_err;
`else
    assign bus.o_parity_err = 1'b0;
`endif

endmodule
